// File: rtl/catraca_pkg.sv
// Shared types and LED codes for the turnstile arbiter.
// The occupancy feature is selected in arbitro_catraca by CATRACA_OCUPACAO_EN.
package catraca_pkg;

    typedef enum logic [1:0] {
        OCIOSO     = 2'b00,
        LIBERA_ENT = 2'b01,
        LIBERA_SAI = 2'b10,
        BLOQUEIO   = 2'b11
    } estado_t;

    typedef enum logic {
        ENTRADA = 1'b0,
        SAIDA   = 1'b1
    } lado_t;

    localparam logic [1:0] LED_OFF   = 2'b00;
    localparam logic [1:0] LED_ENT   = 2'b01;
    localparam logic [1:0] LED_SAI   = 2'b10;
    localparam logic [1:0] LED_AMBOS = 2'b11;

    function automatic logic [1:0] decod_verde(input estado_t estado);
        logic [1:0] leds;
        case (estado)
            LIBERA_ENT: leds = LED_ENT;
            LIBERA_SAI: leds = LED_SAI;
            default:    leds = LED_OFF;
        endcase
        return leds;
    endfunction

    // bit0 shows a full room only while idle; a lock shows both sides blocked
    function automatic logic [1:0] decod_vermelho(input estado_t estado, input logic cheio);
        logic [1:0] leds;
        case (estado)
            OCIOSO:   leds = {1'b0, cheio};
            BLOQUEIO: leds = LED_AMBOS;
            default:  leds = LED_OFF;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/catraca_temporizador.sv
// Loadable down-counter shared by the grant timeout and the metal-lock hold.
// Load wins over decrement; the count rests at zero.
module catraca_temporizador #(
    parameter int LARG = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            carga,
    input  logic            decrementa,
    input  logic [LARG-1:0] valor,
    output logic            zero
);

    logic [LARG-1:0] contagem_r;

    // counter register: reload, count down, or hold
    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_r <= {LARG{1'b0}};
        end else if (carga) begin
            contagem_r <= valor;
        end else if (decrementa && (contagem_r != {LARG{1'b0}})) begin
            contagem_r <= contagem_r - {{(LARG-1){1'b0}}, 1'b1};
        end else begin
            contagem_r <= contagem_r;
        end
    end

    assign zero = (contagem_r == {LARG{1'b0}});

endmodule

// File: rtl/arbitro_catraca.sv
// Turnstile arbiter: round-robin entry/exit grants, metal lock, occupancy.
// Define CATRACA_OCUPACAO_EN to build the occupancy counter and capacity gating.
module arbitro_catraca
    import catraca_pkg::*;
#(
    parameter int TEMPO_MAX      = 50,
    parameter int TEMPO_BLOQUEIO = 20,
    parameter int CAPACIDADE     = 15,
    parameter int LARG_OCUP      = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pedido_entrada,
    input  logic                 pedido_saida,
    input  logic                 metais,
    input  logic                 giro,
    output logic [1:0]           led_verde,
    output logic [1:0]           led_vermelho,
    output logic [LARG_OCUP-1:0] ocupacao,
    output logic                 lotado,
    output logic                 ocupado
);

    localparam int TEMPO_MAIOR = (TEMPO_MAX > TEMPO_BLOQUEIO) ? TEMPO_MAX : TEMPO_BLOQUEIO;
    localparam int LARG_TEMPO  = $clog2(TEMPO_MAIOR + 1);
    localparam logic [LARG_TEMPO-1:0] CARGA_LIBERA   = LARG_TEMPO'(TEMPO_MAX - 1);
    localparam logic [LARG_TEMPO-1:0] CARGA_BLOQUEIO = LARG_TEMPO'(TEMPO_BLOQUEIO - 1);
    localparam logic [LARG_OCUP-1:0]  CAP            = LARG_OCUP'(CAPACIDADE);

    estado_t               estado_r, estado_prox_s;
    lado_t                 ultimo_r, ultimo_prox_s;
    logic                  giro_q_r;
    logic                  giro_borda_s;
    logic                  elig_ent_s, elig_sai_s;
    logic                  carga_s, dec_s, tempo_zero_s;
    logic [LARG_TEMPO-1:0] valor_s;
    logic                  incr_s, decr_s;
    logic [LARG_OCUP-1:0]  ocupacao_r, ocup_prox_s;
    logic                  lotado_r, lotado_prox_s;
    logic [1:0]            led_verde_r, led_vermelho_r;
    logic                  ocupado_r;

    assign giro_borda_s = giro & ~giro_q_r;
    assign elig_sai_s   = pedido_saida;

    catraca_temporizador #(
        .LARG (LARG_TEMPO)
    ) u_temporizador (
        .clock      (clock),
        .reset      (reset),
        .carga      (carga_s),
        .decrementa (dec_s),
        .valor      (valor_s),
        .zero       (tempo_zero_s)
    );

    // next-state, arbitration and timer control
    always_comb begin
        estado_prox_s = estado_r;
        ultimo_prox_s = ultimo_r;
        carga_s       = 1'b0;
        dec_s         = 1'b0;
        valor_s       = CARGA_LIBERA;
        incr_s        = 1'b0;
        decr_s        = 1'b0;
        case (estado_r)
            OCIOSO: begin
                if (elig_ent_s && elig_sai_s) begin
                    carga_s = 1'b1;
                    if (ultimo_r == ENTRADA) begin
                        estado_prox_s = LIBERA_SAI;
                        ultimo_prox_s = SAIDA;
                    end else begin
                        estado_prox_s = LIBERA_ENT;
                        ultimo_prox_s = ENTRADA;
                    end
                end else if (elig_ent_s) begin
                    carga_s       = 1'b1;
                    estado_prox_s = LIBERA_ENT;
                    ultimo_prox_s = ENTRADA;
                end else if (elig_sai_s) begin
                    carga_s       = 1'b1;
                    estado_prox_s = LIBERA_SAI;
                    ultimo_prox_s = SAIDA;
                end else begin
                    estado_prox_s = OCIOSO;
                end
            end
            LIBERA_ENT: begin
                if (metais) begin
                    estado_prox_s = BLOQUEIO;
                    carga_s       = 1'b1;
                    valor_s       = CARGA_BLOQUEIO;
                end else if (giro_borda_s) begin
                    estado_prox_s = OCIOSO;
                    incr_s        = 1'b1;
                end else if (tempo_zero_s) begin
                    estado_prox_s = OCIOSO;
                end else begin
                    dec_s = 1'b1;
                end
            end
            LIBERA_SAI: begin
                if (giro_borda_s) begin
                    estado_prox_s = OCIOSO;
                    decr_s        = 1'b1;
                end else if (tempo_zero_s) begin
                    estado_prox_s = OCIOSO;
                end else begin
                    dec_s = 1'b1;
                end
            end
            BLOQUEIO: begin
                if (metais) begin
                    carga_s = 1'b1;
                    valor_s = CARGA_BLOQUEIO;
                end else if (tempo_zero_s) begin
                    estado_prox_s = OCIOSO;
                end else begin
                    dec_s = 1'b1;
                end
            end
            default: begin
                estado_prox_s = OCIOSO;
            end
        endcase
    end

`ifdef CATRACA_OCUPACAO_EN
    assign elig_ent_s    = pedido_entrada & ~lotado_r;
    assign lotado_prox_s = (ocup_prox_s == CAP);

    // occupancy: +1 never past capacity, -1 saturates at zero
    always_comb begin
        if (incr_s && (ocupacao_r != CAP)) begin
            ocup_prox_s = ocupacao_r + {{(LARG_OCUP-1){1'b0}}, 1'b1};
        end else if (decr_s && (ocupacao_r != {LARG_OCUP{1'b0}})) begin
            ocup_prox_s = ocupacao_r - {{(LARG_OCUP-1){1'b0}}, 1'b1};
        end else begin
            ocup_prox_s = ocupacao_r;
        end
    end
`else
    logic unused_contagem_s;

    assign elig_ent_s        = pedido_entrada;
    assign lotado_prox_s     = 1'b0;
    assign ocup_prox_s       = {LARG_OCUP{1'b0}};
    assign unused_contagem_s = incr_s | decr_s;
`endif

    // state, edge history and outputs decoded from the next state so they appear with it
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r       <= OCIOSO;
            ultimo_r       <= SAIDA;
            giro_q_r       <= 1'b1;
            ocupacao_r     <= {LARG_OCUP{1'b0}};
            lotado_r       <= 1'b0;
            led_verde_r    <= LED_OFF;
            led_vermelho_r <= LED_OFF;
            ocupado_r      <= 1'b0;
        end else begin
            estado_r       <= estado_prox_s;
            ultimo_r       <= ultimo_prox_s;
            giro_q_r       <= giro;
            ocupacao_r     <= ocup_prox_s;
            lotado_r       <= lotado_prox_s;
            led_verde_r    <= decod_verde(estado_prox_s);
            led_vermelho_r <= decod_vermelho(estado_prox_s, lotado_prox_s);
            ocupado_r      <= (estado_prox_s != OCIOSO);
        end
    end

    assign led_verde    = led_verde_r;
    assign led_vermelho = led_vermelho_r;
    assign ocupacao     = ocupacao_r;
    assign lotado       = lotado_r;
    assign ocupado      = ocupado_r;

endmodule
